// File: rtl/rx_4b_frame_pkg.sv
// Shared types and sizing for the SPI receive stage feeding the 4-bit ALU.
package rx_pkg;

    localparam int OPC_W_DEF = 4;
    localparam int OP_W_DEF  = 8;

    // One opcode nibble followed by two operands of OP_W/4 nibbles each.
    function automatic int frame_n(input int op_w);
        return 1 + 2 * (op_w / 4);
    endfunction

    typedef enum logic {
        RX_IDLE,
        RX_RECV
    } rx_state_t;

    typedef struct packed {
        logic [OPC_W_DEF-1:0] opcode;
        logic [OP_W_DEF-1:0]  op_a;
        logic [OP_W_DEF-1:0]  op_b;
    } instr_t;

endpackage

// File: rtl/rx_4b_frame_if.sv
// Instruction handshake between the receive stage (master) and the ALU (slave).
interface rx_4b_frame_if #(
    parameter int OPC_W = 4,
    parameter int OP_W  = 8
);
    logic             instr_valid;
    logic             instr_ready;
    logic [OPC_W-1:0] opcode;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;

    modport master (
        output instr_valid, opcode, op_a, op_b,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, opcode, op_a, op_b,
        output instr_ready
    );
endinterface

// File: rtl/rx_4b_frame_spi_edge_det.sv
// Edge detector for a clk-synchronous SPI clock; prev resets high so a line
// already high at reset release is not seen as a rising edge.
module spi_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= sig_in;
    end

    assign rise = sig_in & ~prev;
    assign fall = ~sig_in & prev;
endmodule

// File: rtl/rx_4b_frame.sv
// Assembles SPI nibbles (LS nibble first) into opcode/op_a/op_b frames and
// presents them to the ALU through a one-entry valid/ready output buffer.
module rx_4b_frame
    import rx_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_w,
    input  logic [3:0]        mosi,
    rx_4b_frame_if.master     alu,
    output logic              rx_busy,
    output logic              rx_overflow,
    output logic              rx_abort
);
    localparam int FRAME_N = frame_n(OP_W);
    localparam int SH_W    = 4 * FRAME_N;
    localparam int CNT_W   = $clog2(FRAME_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_N - 1);

    logic             spi_rise;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  sh;
    logic [SH_W-1:0]  frame_next;
    logic             capture;
    logic             complete;
    logic             take;

    spi_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (spi_clk),
        .rise   (spi_rise),
        .fall   ()
    );

    // Nibbles shift in from the top so n0 ends up in the low bits.
    always_comb begin
        capture    = spi_rise & spi_w;
        frame_next = {mosi, sh[SH_W-1:4]};
        complete   = capture && (cnt == CNT_LAST);
        take       = alu.instr_valid & alu.instr_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RX_IDLE;
            cnt             <= '0;
            sh              <= '0;
            rx_overflow     <= 1'b0;
            rx_abort        <= 1'b0;
            alu.instr_valid <= 1'b0;
            alu.opcode      <= '0;
            alu.op_a        <= '0;
            alu.op_b        <= '0;
        end else begin
            rx_overflow <= 1'b0;
            rx_abort    <= 1'b0;

            if (capture) begin
                sh  <= frame_next;
                cnt <= complete ? '0 : cnt + 1'b1;
            end

            case (state)
                RX_IDLE: if (spi_w) state <= RX_RECV;
                RX_RECV: begin
                    if (!spi_w) begin
                        state <= RX_IDLE;
                        if (cnt != '0) begin
                            rx_abort <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase

            // A full buffer being drained this edge can be refilled in the same edge.
            if (complete) begin
                if (!alu.instr_valid || alu.instr_ready) begin
                    alu.instr_valid <= 1'b1;
                    alu.opcode      <= frame_next[OPC_W-1:0];
                    alu.op_a        <= frame_next[4 +: OP_W];
                    alu.op_b        <= frame_next[4 + OP_W +: OP_W];
                end else begin
                    rx_overflow <= 1'b1;
                end
            end else if (take) begin
                alu.instr_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = (cnt != '0);
endmodule
